// File: rtl/sid_chip_voice.sv
// SID-style voice: 24-bit phase accumulator, tri/saw/pulse/noise generator, ADSR envelope.
// Optional SID_VOICE_RINGMOD_EN: triangle fold bit becomes acc[23]^i_ring_in.
module sid_chip_voice #(
    parameter int AUDIO_BDEPTH    = 8,
    parameter int ACC_BDEPTH      = 24,
    parameter int FREQ_BDEPTH     = 16,
    parameter int ENV_RATE_BDEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_sample_en,
    input  logic [FREQ_BDEPTH-1:0]     i_freq,
    input  logic [11:0]                i_pulse_width,
    input  logic [3:0]                 i_wave_sel,
    input  logic                       i_gate,
    input  logic [ENV_RATE_BDEPTH-1:0] i_attack_rate,
    input  logic [ENV_RATE_BDEPTH-1:0] i_decay_rate,
    input  logic [ENV_RATE_BDEPTH-1:0] i_release_rate,
    input  logic [7:0]                 i_sustain_level,
    input  logic                       i_ring_in,
    output logic                       o_acc_msb,
    output logic [2:0]                 o_env_state,
    output logic [AUDIO_BDEPTH-1:0]    o_audio_out,
    output logic                       o_audio_valid
);

    localparam int STAGES = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } env_state_t;

    logic [ACC_BDEPTH-1:0]      r_acc;
    logic [22:0]                r_lfsr;
    logic [7:0]                 r_env;
    env_state_t                 r_state;
    logic [ENV_RATE_BDEPTH-1:0] r_cnt;
    logic                       r_gate_q;
    logic [STAGES:1]            r_vld_pipe;
    logic [AUDIO_BDEPTH-1:0]    r_audio;

    logic [ACC_BDEPTH-1:0]      w_acc_nxt;
    logic                       w_noise_clk;
    env_state_t                 w_state_nxt;
    logic [7:0]                 w_env_nxt;
    logic [ENV_RATE_BDEPTH-1:0] w_cnt_nxt;
    logic [ENV_RATE_BDEPTH-1:0] w_rate;
    logic                       w_rise;
    logic                       w_fall;
    logic                       w_counting;
    logic                       w_step;
    logic                       w_fold;
    logic [11:0]                w_tri;
    logic [11:0]                w_saw;
    logic [11:0]                w_pulse;
    logic [11:0]                w_noise;
    logic [11:0]                w_wave;
    logic signed [19:0]         w_ws;
    logic signed [19:0]         w_envs;
    logic signed [19:0]         w_prod;

    // ---------------- stage 1: phase accumulator and noise LFSR ----------------
    assign w_acc_nxt   = r_acc + {{(ACC_BDEPTH-FREQ_BDEPTH){1'b0}}, i_freq};
    assign w_noise_clk = i_sample_en & ~r_acc[19] & w_acc_nxt[19];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc      <= '0;
            r_lfsr     <= 23'h7FFFF8;
            r_vld_pipe <= '0;
            r_audio    <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], i_sample_en};
            if (i_sample_en) begin
                r_acc <= w_acc_nxt;
            end
            if (w_noise_clk) begin
                r_lfsr <= {r_lfsr[21:0], r_lfsr[22] ^ r_lfsr[17]};
            end
            if (r_vld_pipe[1]) begin
                r_audio <= w_prod[19 -: AUDIO_BDEPTH];
            end
        end
    end

    // ---------------- ADSR envelope ----------------
    assign w_rise     = i_gate & ~r_gate_q;
    assign w_fall     = ~i_gate & r_gate_q;
    assign w_counting = (r_state == S_ATTACK) || (r_state == S_DECAY) || (r_state == S_RELEASE);
    assign w_step     = i_sample_en && w_counting && (r_cnt >= w_rate);

    always_comb begin
        w_rate = '0;
        case (r_state)
            S_ATTACK:  w_rate = i_attack_rate;
            S_DECAY:   w_rate = i_decay_rate;
            S_RELEASE: w_rate = i_release_rate;
            default:   w_rate = '0;
        endcase
    end

    // Gate edges take priority over a coincident envelope step.
    always_comb begin
        w_state_nxt = r_state;
        w_env_nxt   = r_env;
        w_cnt_nxt   = r_cnt;
        if (i_sample_en && w_counting) begin
            w_cnt_nxt = w_step ? '0 : r_cnt + 1'b1;
        end
        if (w_rise) begin
            w_state_nxt = S_ATTACK;
            w_cnt_nxt   = '0;
        end else if (w_fall && (r_state == S_ATTACK || r_state == S_DECAY ||
                                r_state == S_SUSTAIN)) begin
            w_state_nxt = S_RELEASE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_env_nxt = '0;
                end
                S_ATTACK: begin
                    if (r_env == 8'hFF) begin
                        w_state_nxt = S_DECAY;
                    end else if (w_step) begin
                        w_env_nxt = r_env + 8'd1;
                        if (r_env == 8'hFE) begin
                            w_state_nxt = S_DECAY;
                        end
                    end
                end
                S_DECAY: begin
                    if (r_env <= i_sustain_level) begin
                        w_state_nxt = S_SUSTAIN;
                    end else if (w_step) begin
                        w_env_nxt = r_env - 8'd1;
                    end
                end
                S_SUSTAIN: begin
                    w_state_nxt = S_SUSTAIN;
                end
                S_RELEASE: begin
                    if (r_env == 8'd0) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_step) begin
                        w_env_nxt = r_env - 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_env_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_env    <= '0;
            r_cnt    <= '0;
            r_gate_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_env    <= w_env_nxt;
            r_cnt    <= w_cnt_nxt;
            r_gate_q <= i_gate;
        end
    end

    // ---------------- stage 2: waveform and envelope scaling ----------------
`ifdef SID_VOICE_RINGMOD_EN
    assign w_fold = r_acc[23] ^ i_ring_in;
`else
    logic w_unused_ring;
    assign w_unused_ring = i_ring_in;
    assign w_fold        = r_acc[23];
`endif

    assign w_saw   = r_acc[23:12];
    assign w_tri   = w_fold ? ~r_acc[22:11] : r_acc[22:11];
    assign w_pulse = (r_acc[23:12] >= i_pulse_width) ? 12'hFFF : 12'h000;
    assign w_noise = {r_lfsr[22], r_lfsr[20], r_lfsr[16], r_lfsr[13],
                      r_lfsr[11], r_lfsr[7],  r_lfsr[4],  r_lfsr[2], 4'b0000};

    // Multiple selections combine as a bitwise AND; no selection yields zero.
    always_comb begin
        w_wave = 12'hFFF;
        if (i_wave_sel[0]) w_wave = w_wave & w_tri;
        if (i_wave_sel[1]) w_wave = w_wave & w_saw;
        if (i_wave_sel[2]) w_wave = w_wave & w_pulse;
        if (i_wave_sel[3]) w_wave = w_wave & w_noise;
        if (i_wave_sel == 4'b0000) w_wave = 12'h000;
    end

    assign w_ws   = {{8{~w_wave[11]}}, ~w_wave[11], w_wave[10:0]};
    assign w_envs = {12'b0, r_env};
    assign w_prod = w_ws * w_envs;

    assign o_acc_msb     = r_acc[ACC_BDEPTH-1];
    assign o_env_state   = r_state;
    assign o_audio_out   = r_audio;
    assign o_audio_valid = r_vld_pipe[STAGES];

endmodule
